// File: rtl/booth_div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package booth_div_pkg;

    localparam int W_DEFAULT = 8;
    localparam int MAX_W     = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Two's-complement negate at the widest supported width; callers truncate to W.
    function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] x);
        return ~x + 64'd1;
    endfunction

endpackage

// File: rtl/booth_divider_nr_div_step.sv
// One non-restoring radix-2 step: shift in the next dividend bit, add or subtract |b|.
module nr_div_step #(
    parameter int W = 8
) (
    input  logic [W:0]   p_i,
    input  logic         bit_i,
    input  logic [W-1:0] bmag_i,
    output logic [W:0]   p_new_o,
    output logic         q_bit_o
);

    logic [W:0] shifted_s;
    logic [W:0] bext_s;
    logic [W:0] sum_s;

    // The true result always fits W+1 signed bits, so modulo arithmetic is exact.
    always_comb begin
        shifted_s = {p_i[W-1:0], bit_i};
        bext_s    = {1'b0, bmag_i};
        if (p_i[W] == 1'b0) begin
            sum_s = shifted_s - bext_s;
        end else begin
            sum_s = shifted_s + bext_s;
        end
        p_new_o = sum_s;
        q_bit_o = ~sum_s[W];
    end

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: magnitudes through W non-restoring steps, then a sign-fix cycle.
module booth_divider
    import booth_div_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CW = $clog2(W) + 1;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  bmag_q;
    logic [W-1:0]  qm_q;
    logic [W:0]    p_q;
    logic          sa_q;
    logic          sb_q;
    logic          dz_pend_q;

    logic [W-1:0]  abs_a_s;
    logic [W-1:0]  abs_b_s;
    logic [W:0]    step_p_s;
    logic          step_q_s;
    logic [W:0]    p_fix_d;
    logic [W-1:0]  q_fix_d;
    logic [W-1:0]  r_fix_d;
    logic          ov_d;

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
        return W'(twos_neg(MAX_W'(x)));
    endfunction

    nr_div_step #(.W(W)) u_step (
        .p_i     (p_q),
        .bit_i   (qm_q[W-1]),
        .bmag_i  (bmag_q),
        .p_new_o (step_p_s),
        .q_bit_o (step_q_s)
    );

    // Operand magnitudes and the sign-corrected results applied in FIX.
    always_comb begin
        abs_a_s = a[W-1] ? neg_w(a) : a;
        abs_b_s = b[W-1] ? neg_w(b) : b;
        if (p_q[W] == 1'b1) begin
            p_fix_d = p_q + {1'b0, bmag_q};
        end else begin
            p_fix_d = p_q;
        end
        q_fix_d = (sa_q ^ sb_q) ? neg_w(qm_q) : qm_q;
        r_fix_d = sa_q ? neg_w(p_fix_d[W-1:0]) : p_fix_d[W-1:0];
        ov_d    = (a_q == {1'b1, {(W-1){1'b0}}}) && (b_q == {W{1'b1}});
    end

    // Control FSM with all datapath registers and registered outputs.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            bmag_q      <= '0;
            qm_q        <= '0;
            p_q         <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            dz_pend_q   <= 1'b0;
            q           <= '0;
            r           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q         <= a;
                        b_q         <= b;
                        sa_q        <= a[W-1];
                        sb_q        <= b[W-1];
                        bmag_q      <= abs_b_s;
                        qm_q        <= abs_a_s;
                        p_q         <= '0;
                        cnt_q       <= '0;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        dz_pend_q   <= (b == '0);
                        // A zero divisor skips the iterations and resolves in FIX.
                        state_q     <= (b == '0) ? FIX : ITER;
                    end
                end
                ITER: begin
                    p_q   <= step_p_s;
                    qm_q  <= {qm_q[W-2:0], step_q_s};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (dz_pend_q) begin
                        q           <= {W{1'b1}};
                        r           <= a_q;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else begin
                        q           <= q_fix_d;
                        r           <= r_fix_d;
                        overflow    <= ov_d;
                        p_q         <= p_fix_d;
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_divider.sv
// Scoreboard bench: driver queues expected results, monitor pops them on each done pulse.
module tb_booth_divider;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
    } exp_t;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic       overflow;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    booth_divider #(.W(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .q           (q),
        .r           (r),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
        int   xi;
        int   yi;
        int   qi;
        int   ri;
        exp_t e;
        xi = int'($signed(x));
        yi = int'($signed(y));
        if (y == 8'h00) begin
            e = '{q: 8'hFF, r: x, dz: 1'b1, ov: 1'b0};
        end else if (x == 8'h80 && y == 8'hFF) begin
            e = '{q: 8'h80, r: 8'h00, dz: 1'b0, ov: 1'b1};
        end else begin
            qi = xi / yi;
            ri = xi % yi;
            e = '{q: qi[7:0], r: ri[7:0], dz: 1'b0, ov: 1'b0};
        end
        return e;
    endfunction

    // Monitor: every done pulse consumes one expected result.
    always @(posedge clock) begin
        exp_t e;
        if (reset_n === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                e = sb_q.pop_front();
                chk("q", int'(q), int'(e.q));
                chk("r", int'(r), int'(e.r));
                chk("div_by_zero", int'(div_by_zero), int'(e.dz));
                chk("overflow", int'(overflow), int'(e.ov));
            end
        end
    end

    task automatic run_div(input logic [7:0] ta, input logic [7:0] tb_v, input exp_t e,
                           input int exp_lat, input bit repulse);
        int n;
        bit got;
        @(posedge clock);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        sb_q.push_back(e);
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clock);
            n++;
            if (n == 1) start = 1'b0;
            if (repulse && n == 3) begin
                start = 1'b1;
                a     = 8'd1;
                b     = 8'd1;
            end
            if (repulse && n == 4) start = 1'b0;
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                chk("busy_during_op", int'(busy), 1);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected latency %0d", n, exp_lat);
        end else begin
            chk("latency", n, exp_lat);
            chk("busy_at_done", int'(busy), 0);
        end
    endtask

    initial begin
        exp_t e;
        logic [7:0] ra;
        logic [7:0] rb;
        reset_n = 1'b0;
        start   = 1'b0;
        a       = 8'd0;
        b       = 8'd0;
        repeat (2) @(posedge clock);
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        reset_n = 1'b1;

        run_div(8'd100, 8'd7, '{q: 8'h0E, r: 8'h02, dz: 1'b0, ov: 1'b0}, 10, 1'b0);
        @(posedge clock);
        chk("hold_q", int'(q), 8'h0E);
        chk("done_pulse_low", int'(done), 0);
        run_div(8'h9C, 8'd7, '{q: 8'hF2, r: 8'hFE, dz: 1'b0, ov: 1'b0}, 10, 1'b0);
        run_div(8'd100, 8'hF9, '{q: 8'hF2, r: 8'h02, dz: 1'b0, ov: 1'b0}, 10, 1'b0);
        run_div(8'h80, 8'hFF, '{q: 8'h80, r: 8'h00, dz: 1'b0, ov: 1'b1}, 10, 1'b0);
        run_div(8'h80, 8'h01, '{q: 8'h80, r: 8'h00, dz: 1'b0, ov: 1'b0}, 10, 1'b0);
        run_div(8'd5, 8'd0, '{q: 8'hFF, r: 8'h05, dz: 1'b1, ov: 1'b0}, 2, 1'b0);
        run_div(8'd9, 8'd3, '{q: 8'h03, r: 8'h00, dz: 1'b0, ov: 1'b0}, 10, 1'b0);
        run_div(8'd100, 8'd7, '{q: 8'h0E, r: 8'h02, dz: 1'b0, ov: 1'b0}, 10, 1'b1);
        run_div(8'd7, 8'hFE, '{q: 8'hFD, r: 8'h01, dz: 1'b0, ov: 1'b0}, 10, 1'b0);
        run_div(8'h81, 8'h80, '{q: 8'h00, r: 8'h81, dz: 1'b0, ov: 1'b0}, 10, 1'b0);

        // Abort a division with an asynchronous reset mid-flight.
        @(posedge clock);
        a     = 8'd100;
        b     = 8'd7;
        start = 1'b1;
        @(posedge clock);
        start = 1'b0;
        repeat (3) @(posedge clock);
        chk("busy_before_abort", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("abort_q", int'(q), 0);
        chk("abort_r", int'(r), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_flags", int'({div_by_zero, overflow}), 0);
        @(posedge clock);
        reset_n = 1'b1;
        run_div(8'h7F, 8'h80, '{q: 8'h00, r: 8'h7F, dz: 1'b0, ov: 1'b0}, 10, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i == 0) begin
                ra = 8'h80;
                rb = 8'h80;
            end
            e = model(ra, rb);
            run_div(ra, rb, e, (rb == 8'h00) ? 2 : 10, 1'b0);
        end

        repeat (4) @(posedge clock);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

endmodule
